// File: rtl/ram_port_arbiter_if.sv
// Port-A sharing bus: CPU and SPI requester sides plus the RAM port itself.
// master = requesters/RAM model side, slave = arbiter side.
interface ram_port_arbiter_if #(parameter int ADDR_WIDTH = 16);
    logic                  loading;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [15:0]           cpu_addr;
    logic [7:0]            cpu_din;
    logic [7:0]            cpu_dout;
    logic                  cpu_ack;
    logic                  cpu_wait_n;
    logic                  spi_wr;
    logic                  spi_rd;
    logic [ADDR_WIDTH-1:0] spi_addr;
    logic [7:0]            spi_din;
    logic [7:0]            spi_dout;
    logic                  spi_ack;
    logic                  spi_overrun;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_din;
    logic [7:0]            ram_dout;

    modport master (
        output loading, cpu_req, cpu_we, cpu_addr, cpu_din,
        output spi_wr, spi_rd, spi_addr, spi_din, ram_dout,
        input  cpu_dout, cpu_ack, cpu_wait_n, spi_dout, spi_ack, spi_overrun,
        input  ram_we, ram_addr, ram_din
    );

    modport slave (
        input  loading, cpu_req, cpu_we, cpu_addr, cpu_din,
        input  spi_wr, spi_rd, spi_addr, spi_din, ram_dout,
        output cpu_dout, cpu_ack, cpu_wait_n, spi_dout, spi_ack, spi_overrun,
        output ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates RAM port A between Z80 data accesses and the SPI loader.
// Optional ARB_STATS_EN adds a saturating CPU stall-cycle counter (stall_count, stats_clr).
module ram_port_arbiter #(
    parameter int          ADDR_WIDTH     = 16,
    parameter logic [15:0] RAM_BASE       = 16'h4000,
    parameter int          SPI_STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ARB_STATS_EN
    input  logic               stats_clr,
    output logic [15:0]        stall_count,
`endif
    ram_port_arbiter_if.slave  bus
);
    localparam int SW = $clog2(SPI_STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(SPI_STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE} state_t;

    state_t                state_q, state_d;
    logic                  owner_spi_q, owner_spi_d;
    logic                  op_we_q, op_we_d;
    logic                  cpu_pend_q, cpu_pend_d;
    logic                  cpu_we_q, cpu_we_d;
    logic [ADDR_WIDTH-1:0] cpu_a_q, cpu_a_d;
    logic [7:0]            cpu_d_q, cpu_d_d;
    logic                  spi_pend_q, spi_pend_d;
    logic                  spi_we_q, spi_we_d;
    logic [ADDR_WIDTH-1:0] spi_a_q, spi_a_d;
    logic [7:0]            spi_d_q, spi_d_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_din_q, ram_din_d;
    logic [7:0]            cpu_dout_q, cpu_dout_d;
    logic [7:0]            spi_dout_q, spi_dout_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  spi_ack_q, spi_ack_d;
    logic                  overrun_q, overrun_d;
    logic                  grant_cpu, grant_spi, spi_strobe, wait_n;

    // CPU window starts at RAM_BASE; wraps modulo the RAM address space
    logic [ADDR_WIDTH-1:0] cpu_off;
    assign cpu_off    = ADDR_WIDTH'(bus.cpu_addr) - ADDR_WIDTH'(RAM_BASE);
    assign spi_strobe = bus.spi_wr | bus.spi_rd;
    assign wait_n     = !(cpu_pend_q || (state_q != S_IDLE && !owner_spi_q));

    always_comb begin
        state_d     = state_q;
        owner_spi_d = owner_spi_q;
        op_we_d     = op_we_q;
        cpu_pend_d  = cpu_pend_q;
        cpu_we_d    = cpu_we_q;
        cpu_a_d     = cpu_a_q;
        cpu_d_d     = cpu_d_q;
        spi_pend_d  = spi_pend_q;
        spi_we_d    = spi_we_q;
        spi_a_d     = spi_a_q;
        spi_d_d     = spi_d_q;
        starve_d    = starve_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        cpu_dout_d  = cpu_dout_q;
        spi_dout_d  = spi_dout_q;
        cpu_ack_d   = 1'b0;
        spi_ack_d   = 1'b0;
        overrun_d   = overrun_q;
        grant_cpu   = 1'b0;
        grant_spi   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (spi_pend_q && (!cpu_pend_q || bus.loading || starve_q == STARVE_MAX))
                    grant_spi = 1'b1;
                else if (cpu_pend_q && !bus.loading)
                    grant_cpu = 1'b1;
                if (grant_spi || grant_cpu) begin
                    state_d     = S_ACCESS;
                    owner_spi_d = grant_spi;
                    op_we_d     = grant_spi ? spi_we_q : cpu_we_q;
                    ram_we_d    = grant_spi ? spi_we_q : cpu_we_q;
                    ram_addr_d  = grant_spi ? spi_a_q  : cpu_a_q;
                    ram_din_d   = grant_spi ? spi_d_q  : cpu_d_q;
                end
            end
            S_ACCESS: begin
                ram_we_d = 1'b0;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                if (owner_spi_q) begin
                    spi_ack_d = 1'b1;
                    if (!op_we_q) spi_dout_d = bus.ram_dout;
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!op_we_q) cpu_dout_d = bus.ram_dout;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant_spi)
            starve_d = '0;
        else if (grant_cpu && spi_pend_q && starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);

        if (grant_cpu) cpu_pend_d = 1'b0;
        if (bus.cpu_req && !cpu_pend_q) begin
            cpu_pend_d = 1'b1;
            cpu_we_d   = bus.cpu_we;
            cpu_a_d    = cpu_off;
            cpu_d_d    = bus.cpu_din;
        end

        // A strobe landing on its own grant edge refills the slot being vacated
        if (grant_spi) spi_pend_d = 1'b0;
        if (spi_strobe) begin
            if (!spi_pend_q || grant_spi) begin
                spi_pend_d = 1'b1;
                spi_we_d   = bus.spi_wr;
                spi_a_d    = bus.spi_addr;
                spi_d_d    = bus.spi_din;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_spi_q <= 1'b0;
            op_we_q     <= 1'b0;
            cpu_pend_q  <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_a_q     <= '0;
            cpu_d_q     <= '0;
            spi_pend_q  <= 1'b0;
            spi_we_q    <= 1'b0;
            spi_a_q     <= '0;
            spi_d_q     <= '0;
            starve_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cpu_dout_q  <= '0;
            spi_dout_q  <= '0;
            cpu_ack_q   <= 1'b0;
            spi_ack_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_spi_q <= owner_spi_d;
            op_we_q     <= op_we_d;
            cpu_pend_q  <= cpu_pend_d;
            cpu_we_q    <= cpu_we_d;
            cpu_a_q     <= cpu_a_d;
            cpu_d_q     <= cpu_d_d;
            spi_pend_q  <= spi_pend_d;
            spi_we_q    <= spi_we_d;
            spi_a_q     <= spi_a_d;
            spi_d_q     <= spi_d_d;
            starve_q    <= starve_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            cpu_dout_q  <= cpu_dout_d;
            spi_dout_q  <= spi_dout_d;
            cpu_ack_q   <= cpu_ack_d;
            spi_ack_q   <= spi_ack_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.cpu_dout    = cpu_dout_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_wait_n  = wait_n;
    assign bus.spi_dout    = spi_dout_q;
    assign bus.spi_ack     = spi_ack_q;
    assign bus.spi_overrun = overrun_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_din     = ram_din_q;

`ifdef ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (stats_clr)
            stall_d = '0;
        else if (!wait_n && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: expected RAM writes and acks are queued
// as stimulus is driven and retired by a negedge monitor.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter_if #(.ADDR_WIDTH(16)) bus();

`ifdef ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] stall_count;
`endif

  ram_port_arbiter #(.ADDR_WIDTH(16), .RAM_BASE(16'h4000), .SPI_STARVE_MAX(4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef ARB_STATS_EN
    .stats_clr(stats_clr),
    .stall_count(stall_count),
`endif
    .bus(bus)
  );

  // RAM model: synchronous write, read data one cycle after address
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (reset) mem[16'h1234] <= 8'h3C;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  typedef struct { logic [15:0] a; logic [7:0] d; int cyc; } wr_t;
  typedef struct { logic rd; logic [7:0] d; int cyc; } ack_t;
  wr_t  exp_wr[$];
  ack_t exp_cpu[$];
  ack_t exp_spi[$];
  logic prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  assert property (@(posedge clk) disable iff (reset) !(bus.cpu_req && dut.cpu_pend_q))
    else $error("cpu_req issued while a CPU request is still pending");

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ram_we) begin
        chk("we_width", 32'(prev_we), 0);
        chk("wr_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          chk("wr_addr", 32'(bus.ram_addr), 32'(exp_wr[0].a));
          chk("wr_data", 32'(bus.ram_din), 32'(exp_wr[0].d));
          if (exp_wr[0].cyc >= 0) chk("wr_cyc", cyc, exp_wr[0].cyc);
          void'(exp_wr.pop_front());
        end
      end
      if (bus.cpu_ack) begin
        chk("cpu_ack_expected", 32'(exp_cpu.size() > 0), 1);
        if (exp_cpu.size() > 0) begin
          if (exp_cpu[0].cyc >= 0) chk("cpu_ack_cyc", cyc, exp_cpu[0].cyc);
          if (exp_cpu[0].rd) chk("cpu_dout", 32'(bus.cpu_dout), 32'(exp_cpu[0].d));
          void'(exp_cpu.pop_front());
        end
      end
      if (bus.spi_ack) begin
        chk("spi_ack_expected", 32'(exp_spi.size() > 0), 1);
        if (exp_spi.size() > 0) begin
          if (exp_spi[0].cyc >= 0) chk("spi_ack_cyc", cyc, exp_spi[0].cyc);
          if (exp_spi[0].rd) chk("spi_dout", 32'(bus.spi_dout), 32'(exp_spi[0].d));
          void'(exp_spi.pop_front());
        end
      end
    end
    prev_we <= bus.ram_we;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // wofs/aofs: expected write/ack cycle relative to this strobe cycle, 0 = untimed
  task automatic cpu_set(input logic we, input logic [15:0] a, input logic [7:0] d,
                         input bit push, input int wofs, input int aofs, input logic [7:0] rexp);
    wr_t w;
    ack_t k;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
    if (push) begin
      if (we) begin
        w.a = a - 16'h4000; w.d = d; w.cyc = (wofs != 0) ? cyc + wofs : -1;
        exp_wr.push_back(w);
      end
      k.rd = !we; k.d = rexp; k.cyc = (aofs != 0) ? cyc + aofs : -1;
      exp_cpu.push_back(k);
    end
  endtask

  task automatic spi_set(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d,
                         input bit push, input int wofs, input int aofs, input logic [7:0] rexp);
    wr_t w;
    ack_t k;
    bus.spi_wr = wr; bus.spi_rd = rd; bus.spi_addr = a; bus.spi_din = d;
    if (push) begin
      if (wr) begin
        w.a = a; w.d = d; w.cyc = (wofs != 0) ? cyc + wofs : -1;
        exp_wr.push_back(w);
      end
      k.rd = !wr; k.d = rexp; k.cyc = (aofs != 0) ? cyc + aofs : -1;
      exp_spi.push_back(k);
    end
  endtask

  task automatic clr_strobes();
    bus.cpu_req = 1'b0;
    bus.spi_wr  = 1'b0;
    bus.spi_rd  = 1'b0;
  endtask

  task automatic cpu_pulse(input logic we, input logic [15:0] a, input logic [7:0] d,
                           input bit push, input int wofs, input int aofs, input logic [7:0] rexp);
    cpu_set(we, a, d, push, wofs, aofs, rexp);
    tick();
    clr_strobes();
  endtask

  task automatic spi_pulse(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d,
                           input bit push, input int wofs, input int aofs, input logic [7:0] rexp);
    spi_set(wr, rd, a, d, push, wofs, aofs, rexp);
    tick();
    clr_strobes();
  endtask

  initial begin
    wr_t w;
    ack_t k;
    reset = 1'b1;
    bus.loading = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.spi_addr = '0; bus.spi_din = '0;
    clr_strobes();
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    idle(2);
    chk("rst_cpu_dout", 32'(bus.cpu_dout), 0);
    chk("rst_spi_dout", 32'(bus.spi_dout), 0);
    chk("rst_acks", 32'({bus.cpu_ack, bus.spi_ack}), 0);
    chk("rst_wait_n", 32'(bus.cpu_wait_n), 1);
    chk("rst_overrun", 32'(bus.spi_overrun), 0);
    chk("rst_ram", 32'({bus.ram_we, bus.ram_addr, bus.ram_din}), 0);
    reset = 1'b0;
    idle(2);

    // CPU write then read back, idle arbiter
    cpu_pulse(1'b1, 16'h4010, 8'hA5, 1'b1, 2, 4, 8'h00);
    chk("wait_lo_after_req", 32'(bus.cpu_wait_n), 0);
    idle(2);
    chk("wait_lo_capture", 32'(bus.cpu_wait_n), 0);
    tick();
    chk("wait_hi_at_ack", 32'(bus.cpu_wait_n), 1);
    idle(3);
    cpu_pulse(1'b0, 16'h4010, 8'h00, 1'b1, 0, 4, 8'hA5);
    idle(6);

    // CPU address below RAM_BASE wraps
    cpu_pulse(1'b1, 16'h0005, 8'h5A, 1'b1, 2, 4, 8'h00);
    idle(6);

    // wr+rd together is a write; read it back
    spi_pulse(1'b1, 1'b1, 16'h2000, 8'h99, 1'b1, 2, 4, 8'h00);
    idle(6);
    spi_pulse(1'b0, 1'b1, 16'h2000, 8'h00, 1'b1, 0, 4, 8'h99);
    idle(6);

    // loading: SPI read serviced, concurrent CPU write held
    bus.loading = 1'b1;
    cpu_set(1'b1, 16'h4020, 8'h77, 1'b1, 0, 0, 8'h00);
    spi_set(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 0, 4, 8'h3C);
    tick();
    clr_strobes();
    for (int i = 0; i < 12; i++) begin
      chk("wait_lo_loading", 32'(bus.cpu_wait_n), 0);
      tick();
    end
    chk("no_we_loading", 32'(bus.ram_we), 0);
    bus.loading = 1'b0;
    idle(2);
    chk("wait_lo_service", 32'(bus.cpu_wait_n), 0);
    tick();
    chk("wait_hi_release", 32'(bus.cpu_wait_n), 1);
    idle(4);

    // strobe coincident with its own grant edge is accepted, back-to-back 3-cycle accesses
    spi_pulse(1'b1, 1'b0, 16'h3000, 8'h01, 1'b1, 2, 4, 8'h00);
    spi_pulse(1'b1, 1'b0, 16'h3001, 8'h02, 1'b1, 4, 6, 8'h00);
    idle(8);
    chk("no_overrun_grant_edge", 32'(bus.spi_overrun), 0);

    // starvation guard: 4 CPU grants, then SPI, then CPU again
    cpu_set(1'b1, 16'h4100, 8'hC0, 1'b1, 0, 0, 8'h00);
    spi_set(1'b1, 1'b0, 16'h3200, 8'h11, 1'b0, 0, 0, 8'h00);
    tick();
    clr_strobes();
    tick();
    cpu_pulse(1'b1, 16'h4101, 8'hC1, 1'b1, 0, 0, 8'h00);
    idle(2);
    cpu_pulse(1'b1, 16'h4102, 8'hC2, 1'b1, 0, 0, 8'h00);
    idle(2);
    cpu_pulse(1'b1, 16'h4103, 8'hC3, 1'b1, 0, 0, 8'h00);
    w.a = 16'h3200; w.d = 8'h11; w.cyc = -1;
    exp_wr.push_back(w);
    k.rd = 1'b0; k.d = 8'h00; k.cyc = -1;
    exp_spi.push_back(k);
    idle(2);
    cpu_pulse(1'b1, 16'h4104, 8'hC4, 1'b1, 0, 0, 8'h00);
    chk("starve_sat", 32'(dut.starve_q), 4);
    idle(10);
    chk("starve_clr", 32'(dut.starve_q), 0);

    // overrun: second SPI strobe while first still pending behind CPU
    cpu_pulse(1'b1, 16'h4200, 8'h42, 1'b1, 2, 4, 8'h00);
    spi_pulse(1'b1, 1'b0, 16'h3100, 8'hAA, 1'b1, 4, 6, 8'h00);
    chk("overrun_before", 32'(bus.spi_overrun), 0);
    spi_pulse(1'b1, 1'b0, 16'h3101, 8'hBB, 1'b0, 0, 0, 8'h00);
    chk("overrun_set", 32'(bus.spi_overrun), 1);
    idle(8);
    chk("overrun_sticky", 32'(bus.spi_overrun), 1);

    // reset in the middle of a CPU write
    cpu_pulse(1'b1, 16'h4300, 8'hEE, 1'b0, 0, 0, 8'h00);
    tick();
    reset = 1'b1;
    #1;
    chk("rstmid_we", 32'(bus.ram_we), 0);
    chk("rstmid_wait_n", 32'(bus.cpu_wait_n), 1);
    chk("rstmid_overrun", 32'(bus.spi_overrun), 0);
    chk("rstmid_cpu_dout", 32'(bus.cpu_dout), 0);
    chk("rstmid_spi_dout", 32'(bus.spi_dout), 0);
    tick();
    reset = 1'b0;
    idle(6);
    chk("rstmid_no_write", 32'(mem[16'h0300]), 32'hxx);

`ifdef ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    bus.loading = 1'b1;
    cpu_pulse(1'b1, 16'h4400, 8'h44, 1'b1, 0, 11, 8'h00);
    idle(7);
    bus.loading = 1'b0;
    idle(3);
    chk("stall_count", 32'(stall_count), 10);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("stall_clr", 32'(stall_count), 0);
    idle(4);
`endif

    chk("wr_q_empty", exp_wr.size(), 0);
    chk("cpu_q_empty", exp_cpu.size(), 0);
    chk("spi_q_empty", exp_spi.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
